// File: rtl/dynamic_bus_sizer_if.sv
// Signal bundle shared by the CPU side, the bus sizer and the external bus.
//
// Handshake: nTS_CPU is a one-cycle request that is accepted only while the
// sizer is idle. A/SIZ/RnW are captured with it, and pulses that arrive while
// a transfer is in flight are dropped. Each bus sub-cycle opens with a
// one-cycle nTS. The slave terminates a sub-cycle on any later rising edge by
// presenting DSACK != 11 and/or nTEA low. DSACK = 11 with nTEA high means
// "not yet". Each CPU beat is closed by exactly one one-cycle pulse, either
// nTA (data) or nTEA_CPU (error/timeout).
interface dynamic_bus_sizer_if;
  logic        nTS_CPU;
  logic [1:0]  A;
  logic [1:0]  SIZ;
  logic        RnW;
  logic [31:0] CPU_WD;
  logic [31:0] CPU_RD;
  logic        nTA;
  logic        nTEA_CPU;
  logic        nTBI_CPU;
  logic        nTCI_CPU;
  logic        nTS;
  logic [1:0]  BUS_A;
  logic        BUS_RnW;
  logic [31:0] BUS_WD;
  logic [31:0] BUS_RD;
  logic [1:0]  DSACK;
  logic        nTEA;
  logic        nTBI;
  logic        nTCI;
  logic [2:0]  STATE_DBG;

  modport slave (
    input  nTS_CPU, A, SIZ, RnW, CPU_WD, BUS_RD, DSACK, nTEA, nTBI, nTCI,
    output CPU_RD, nTA, nTEA_CPU, nTBI_CPU, nTCI_CPU, nTS, BUS_A, BUS_RnW,
           BUS_WD, STATE_DBG
  );

  modport master (
    output nTS_CPU, A, SIZ, RnW, CPU_WD, BUS_RD, DSACK, nTEA, nTBI, nTCI,
    input  CPU_RD, nTA, nTEA_CPU, nTBI_CPU, nTCI_CPU, nTS, BUS_A, BUS_RnW,
           BUS_WD, STATE_DBG
  );
endinterface

// File: rtl/dynamic_bus_sizer.sv
// Dynamic bus sizer. It splits a CPU byte/word/long/line transfer into
// sub-cycles sized by the DSACK port-width answer. Read bytes are assembled
// into CPU_RD and write bytes are steered onto the upper lanes. 32-bit ports
// get line bursts. Bus errors and a wait timeout abort the whole transfer.
module dynamic_bus_sizer #(
  parameter int TIMEOUT  = 64,
  parameter bit BURST_EN = 1'b1
) (
  input logic                BCLK,
  input logic                RESET,
  dynamic_bus_sizer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t      r_state,  w_state_nxt;
  logic [1:0]  r_a_cur,  w_a_cur_nxt;
  logic [2:0]  r_remain, w_remain_nxt;
  logic [1:0]  r_beat,   w_beat_nxt;
  logic        r_rnw,    w_rnw_nxt;
  logic        r_line,   w_line_nxt;
  logic        r_burst,  w_burst_nxt;
  logic        r_tbi,    w_tbi_nxt;
  logic        r_tci,    w_tci_nxt;
  logic [10:0] r_cnt,    w_cnt_nxt;
  logic [31:0] r_rd,     w_rd_nxt;

  logic [2:0]  w_width;
  logic [2:0]  w_off;
  logic [2:0]  w_avail;
  logic [2:0]  w_moved;
  logic [31:0] w_rd_merge;
  logic [7:0]  w_wd_b0;
  logic [7:0]  w_wd_b1;
  logic [10:0] w_cnt_inc;

  // Port width from DSACK, and the bytes this ack moves from the current offset.
  always_comb begin
    w_width = 3'd4;
    w_off   = {1'b0, r_a_cur};
    case (bus.DSACK)
      2'b01: begin
        w_width = 3'd2;
        w_off   = {2'b00, r_a_cur[0]};
      end
      2'b10: begin
        w_width = 3'd1;
        w_off   = 3'd0;
      end
      default: ;
    endcase
    w_avail = w_width - w_off;
    w_moved = (r_remain < w_avail) ? r_remain : w_avail;
  end

  // Merge the moved bytes into their CPU lanes. The bus lane they come from
  // depends on the port width. Lanes outside the window keep their value.
  always_comb begin
    w_rd_merge = r_rd;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) >= {1'b0, r_a_cur}) && (3'(i) < ({1'b0, r_a_cur} + w_moved))) begin
        case (bus.DSACK)
          2'b00:   w_rd_merge[31-8*i -: 8] = bus.BUS_RD[31-8*i -: 8];
          2'b01:   w_rd_merge[31-8*i -: 8] = ((i % 2) == 0) ? bus.BUS_RD[31:24]
                                                             : bus.BUS_RD[23:16];
          default: w_rd_merge[31-8*i -: 8] = bus.BUS_RD[31:24];
        endcase
      end
    end
  end

  // Write steering: byte(A_CUR) and byte(A_CUR|1) go on the upper lanes.
  always_comb begin
    case (r_a_cur)
      2'b00:   w_wd_b0 = bus.CPU_WD[31:24];
      2'b01:   w_wd_b0 = bus.CPU_WD[23:16];
      2'b10:   w_wd_b0 = bus.CPU_WD[15:8];
      default: w_wd_b0 = bus.CPU_WD[7:0];
    endcase
    w_wd_b1 = r_a_cur[1] ? bus.CPU_WD[7:0] : bus.CPU_WD[23:16];
  end

  assign w_cnt_inc = r_cnt + 11'd1;

  // Next-state and datapath updates. The START cycle counts toward the wait
  // budget, so the abort pulse lands TIMEOUT cycles after nTS.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_cur_nxt  = r_a_cur;
    w_remain_nxt = r_remain;
    w_beat_nxt   = r_beat;
    w_rnw_nxt    = r_rnw;
    w_line_nxt   = r_line;
    w_burst_nxt  = r_burst;
    w_tbi_nxt    = r_tbi;
    w_tci_nxt    = r_tci;
    w_cnt_nxt    = r_cnt;
    w_rd_nxt     = r_rd;
    case (r_state)
      S_IDLE: begin
        if (!bus.nTS_CPU) begin
          w_rnw_nxt   = bus.RnW;
          w_line_nxt  = (bus.SIZ == 2'b11);
          w_burst_nxt = 1'b0;
          w_beat_nxt  = 2'd0;
          w_tbi_nxt   = 1'b0;
          w_tci_nxt   = 1'b0;
          case (bus.SIZ)
            2'b01: begin
              w_remain_nxt = 3'd1;
              w_a_cur_nxt  = bus.A;
            end
            2'b10: begin
              w_remain_nxt = 3'd2;
              w_a_cur_nxt  = {bus.A[1], 1'b0};
            end
            default: begin
              w_remain_nxt = 3'd4;
              w_a_cur_nxt  = 2'b00;
            end
          endcase
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt   = 11'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.nTEA) begin
          w_state_nxt = S_ABORT;
        end else if (bus.DSACK != 2'b11) begin
          w_a_cur_nxt  = r_a_cur + w_moved[1:0];
          w_remain_nxt = r_remain - w_moved;
          w_tbi_nxt    = r_tbi | ~bus.nTBI;
          w_tci_nxt    = r_tci | ~bus.nTCI;
          if (r_rnw) begin
            w_rd_nxt = w_rd_merge;
          end
          // The first ack of a line decides whether it bursts.
          if (r_line && (r_beat == 2'd0) && (r_remain == 3'd4) && (r_a_cur == 2'b00)) begin
            w_burst_nxt = BURST_EN && (bus.DSACK == 2'b00);
          end
          w_state_nxt = ((r_remain - w_moved) != 3'd0) ? S_START : S_ACK;
        end else if ((w_cnt_inc + 11'd1) >= 11'(TIMEOUT)) begin
          w_state_nxt = S_ABORT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_ACK: begin
        if (r_burst && (r_beat != 2'd3)) begin
          w_beat_nxt   = r_beat + 2'd1;
          w_remain_nxt = 3'd4;
          w_a_cur_nxt  = 2'b00;
          w_tbi_nxt    = 1'b0;
          w_tci_nxt    = 1'b0;
          w_state_nxt  = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge BCLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_a_cur  <= 2'b00;
      r_remain <= 3'd0;
      r_beat   <= 2'd0;
      r_rnw    <= 1'b1;
      r_line   <= 1'b0;
      r_burst  <= 1'b0;
      r_tbi    <= 1'b0;
      r_tci    <= 1'b0;
      r_cnt    <= 11'd0;
      r_rd     <= 32'hFFFF_FFFF;
    end else begin
      r_state  <= w_state_nxt;
      r_a_cur  <= w_a_cur_nxt;
      r_remain <= w_remain_nxt;
      r_beat   <= w_beat_nxt;
      r_rnw    <= w_rnw_nxt;
      r_line   <= w_line_nxt;
      r_burst  <= w_burst_nxt;
      r_tbi    <= w_tbi_nxt;
      r_tci    <= w_tci_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd     <= w_rd_nxt;
    end
  end

  assign bus.nTS       = (r_state != S_START);
  assign bus.nTA       = (r_state != S_ACK);
  assign bus.nTEA_CPU  = (r_state != S_ABORT);
  assign bus.nTBI_CPU  = !((r_state == S_ACK) && (r_tbi || (r_line && !r_burst)));
  assign bus.nTCI_CPU  = !((r_state == S_ACK) && r_tci);
  assign bus.BUS_A     = r_a_cur;
  assign bus.BUS_RnW   = (r_state == S_IDLE) ? 1'b1 : r_rnw;
  assign bus.BUS_WD    = {w_wd_b0, w_wd_b1, bus.CPU_WD[15:0]};
  assign bus.CPU_RD    = r_rd;
  assign bus.STATE_DBG = r_state;

endmodule

// File: tb/tb_dynamic_bus_sizer.sv
// Directed bench for dynamic_bus_sizer. A bus-slave responder answers each
// nTS from a response queue. Expected BUS_A, write bytes, read data and
// TBI/TCI terminations are queued when a transfer is set up, then popped as
// the DUT produces them.
module tb_dynamic_bus_sizer;

  typedef struct packed {
    logic [1:0]  dsack;
    logic [31:0] rd;
    logic [7:0]  wait_n;
    logic        tea_n;
    logic        tbi_n;
    logic        tci_n;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   last_nts_cyc = 0;
  int   ntea_cyc = 0;

  logic [1:0]  exp_a_q[$];
  logic [7:0]  exp_wd_q[$];
  logic [31:0] exp_rd_q[$];
  logic        exp_tbi_q[$];
  logic        exp_tci_q[$];
  resp_t       resp_q[$];

  dynamic_bus_sizer_if bif();

  dynamic_bus_sizer #(.TIMEOUT(64), .BURST_EN(1'b1)) dut (
    .BCLK  (clk),
    .RESET (rst),
    .bus   (bif)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_resp(input logic [1:0] dsack, input logic [31:0] rd, input int wait_n,
                          input logic tea_n, input logic tbi_n, input logic tci_n);
    resp_t r;
    r.dsack = dsack; r.rd = rd; r.wait_n = 8'(wait_n);
    r.tea_n = tea_n; r.tbi_n = tbi_n; r.tci_n = tci_n;
    resp_q.push_back(r);
  endtask

  task automatic expect_ta(input logic [31:0] rd, input logic tbi_n, input logic tci_n);
    exp_rd_q.push_back(rd);
    exp_tbi_q.push_back(tbi_n);
    exp_tci_q.push_back(tci_n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_nts"},      32'(bif.nTS),       32'd1);
    check({tag, "_nta"},      32'(bif.nTA),       32'd1);
    check({tag, "_ntea_cpu"}, 32'(bif.nTEA_CPU),  32'd1);
    check({tag, "_ntbi_cpu"}, 32'(bif.nTBI_CPU),  32'd1);
    check({tag, "_ntci_cpu"}, 32'(bif.nTCI_CPU),  32'd1);
    check({tag, "_bus_a"},    32'(bif.BUS_A),     32'd0);
    check({tag, "_bus_rnw"},  32'(bif.BUS_RnW),   32'd1);
    check({tag, "_cpu_rd"},   bif.CPU_RD,         32'hFFFF_FFFF);
    check({tag, "_state"},    32'(bif.STATE_DBG), 32'd0);
  endtask

  // Issue one CPU transfer and act as the bus slave until it terminates.
  // All driving and sampling happens on the falling edge.
  task automatic do_xfer(input string tag, input logic [1:0] a, input logic [1:0] siz,
                         input logic rnw, input logic [31:0] wd, input int exp_nts,
                         input int exp_nta, input int exp_ntea, input int reset_at_nts,
                         input bit poke);
    int    nts_n = 0, nta_n = 0, ntea_n = 0, both_n = 0, settle = 0, wcnt = 0;
    bit    pending = 1'b0;
    resp_t cur = '0;
    logic [31:0] exp_rd;
    @(negedge clk);
    bif.nTS_CPU = 1'b0; bif.A = a; bif.SIZ = siz; bif.RnW = rnw; bif.CPU_WD = wd;
    @(negedge clk);
    bif.nTS_CPU = 1'b1;
    for (int cyc = 0; cyc < 400 && settle < 3; cyc++) begin
      bif.DSACK = 2'b11; bif.nTEA = 1'b1; bif.nTBI = 1'b1; bif.nTCI = 1'b1;
      bif.BUS_RD = 32'h0F0F_0F0F;
      bif.nTS_CPU = !(poke && (cyc == 2));
      if (!bif.nTS) begin
        nts_n++;
        last_nts_cyc = cyc;
        if (exp_a_q.size() > 0) check({tag, "_bus_a"}, 32'(bif.BUS_A), 32'(exp_a_q.pop_front()));
        check({tag, "_bus_rnw"}, 32'(bif.BUS_RnW), 32'(rnw));
        if (!rnw && exp_wd_q.size() > 0)
          check({tag, "_bus_wd_hi"}, 32'(bif.BUS_WD[31:24]), 32'(exp_wd_q.pop_front()));
        if (resp_q.size() > 0) begin
          cur = resp_q.pop_front();
          wcnt = int'(cur.wait_n);
          pending = 1'b1;
        end
        if (nts_n == reset_at_nts) begin
          rst = 1'b1;
          return;
        end
      end else if (pending) begin
        if (wcnt == 0) begin
          bif.DSACK = cur.dsack; bif.BUS_RD = cur.rd; bif.nTEA = cur.tea_n;
          bif.nTBI = cur.tbi_n; bif.nTCI = cur.tci_n;
          pending = 1'b0;
        end else begin
          wcnt--;
        end
      end
      if (!bif.nTA) begin
        nta_n++;
        if (exp_rd_q.size() > 0) begin
          exp_rd = exp_rd_q.pop_front();
          if (rnw) check({tag, "_cpu_rd"}, bif.CPU_RD, exp_rd);
        end
        if (exp_tbi_q.size() > 0) check({tag, "_ntbi_cpu"}, 32'(bif.nTBI_CPU), 32'(exp_tbi_q.pop_front()));
        if (exp_tci_q.size() > 0) check({tag, "_ntci_cpu"}, 32'(bif.nTCI_CPU), 32'(exp_tci_q.pop_front()));
      end
      if (!bif.nTEA_CPU) begin
        ntea_n++;
        ntea_cyc = cyc;
      end
      if (!bif.nTA && !bif.nTEA_CPU) both_n++;
      if (nta_n >= exp_nta && ntea_n >= exp_ntea) settle++;
      @(negedge clk);
    end
    check({tag, "_nts_count"},  32'(nts_n),  32'(exp_nts));
    check({tag, "_nta_count"},  32'(nta_n),  32'(exp_nta));
    check({tag, "_ntea_count"}, 32'(ntea_n), 32'(exp_ntea));
    check({tag, "_ta_tea_overlap"}, 32'(both_n), 32'd0);
    check({tag, "_state_idle"}, 32'(bif.STATE_DBG), 32'd0);
  endtask

  initial begin
    bif.nTS_CPU = 1'b1; bif.A = 2'b00; bif.SIZ = 2'b00; bif.RnW = 1'b1;
    bif.CPU_WD = 32'd0; bif.BUS_RD = 32'd0; bif.DSACK = 2'b11;
    bif.nTEA = 1'b1; bif.nTBI = 1'b1; bif.nTCI = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Long read through a 16-bit port
    add_resp(2'b01, 32'h1234_C3C3, 0, 1, 1, 1);
    add_resp(2'b01, 32'h5678_A5A5, 1, 1, 1, 1);
    exp_a_q.push_back(2'b00); exp_a_q.push_back(2'b10);
    expect_ta(32'h1234_5678, 1'b1, 1'b1);
    do_xfer("long_rd16", 2'b00, 2'b00, 1'b1, 32'd0, 2, 1, 0, 0, 1'b0);

    // Byte write at A=3 to an 8-bit port
    add_resp(2'b10, 32'd0, 2, 1, 1, 1);
    exp_a_q.push_back(2'b11); exp_wd_q.push_back(8'hAB);
    expect_ta(32'd0, 1'b1, 1'b1);
    do_xfer("byte_wr8", 2'b11, 2'b01, 1'b0, 32'h0000_00AB, 1, 1, 0, 0, 1'b0);

    // Long read through an 8-bit port, with a stray nTS_CPU mid-transfer
    add_resp(2'b10, 32'h11EE_EEEE, 0, 1, 1, 1);
    add_resp(2'b10, 32'h22EE_EEEE, 0, 1, 1, 1);
    add_resp(2'b10, 32'h33EE_EEEE, 0, 1, 1, 1);
    add_resp(2'b10, 32'h44EE_EEEE, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) exp_a_q.push_back(2'(i));
    expect_ta(32'h1122_3344, 1'b1, 1'b1);
    do_xfer("long_rd8", 2'b00, 2'b00, 1'b1, 32'd0, 4, 1, 0, 0, 1'b1);

    // Word read at A=2 from a 32-bit port, cache inhibit returned
    add_resp(2'b00, 32'hAABB_CCDD, 0, 1, 1, 0);
    exp_a_q.push_back(2'b10);
    expect_ta(32'h1122_CCDD, 1'b1, 1'b0);
    do_xfer("word_rd32", 2'b10, 2'b10, 1'b1, 32'd0, 1, 1, 0, 0, 1'b0);

    // Word read at A=1 is aligned down to 0, 16-bit port
    add_resp(2'b01, 32'h5A6B_0000, 0, 1, 1, 1);
    exp_a_q.push_back(2'b00);
    expect_ta(32'h5A6B_CCDD, 1'b1, 1'b1);
    do_xfer("word_rd16_align", 2'b01, 2'b10, 1'b1, 32'd0, 1, 1, 0, 0, 1'b0);

    // Byte read at odd address on a 16-bit port takes D[23:16]
    add_resp(2'b01, 32'h0077_0000, 0, 1, 1, 1);
    exp_a_q.push_back(2'b01);
    expect_ta(32'h5A77_CCDD, 1'b1, 1'b1);
    do_xfer("byte_rd16_odd", 2'b01, 2'b01, 1'b1, 32'd0, 1, 1, 0, 0, 1'b0);

    // Line read, 32-bit port: four-beat burst
    for (int i = 1; i <= 4; i++) begin
      add_resp(2'b00, {4{4'(i), 4'h0}}, i % 2, 1, 1, 1);
      exp_a_q.push_back(2'b00);
      expect_ta({4{4'(i), 4'h0}}, 1'b1, 1'b1);
    end
    do_xfer("line_burst", 2'b00, 2'b11, 1'b1, 32'd0, 4, 4, 0, 0, 1'b0);

    // Line read, 16-bit port: one longword, terminated with TBI
    add_resp(2'b01, 32'hABCD_1111, 0, 1, 1, 1);
    add_resp(2'b01, 32'hEF01_2222, 0, 1, 1, 1);
    exp_a_q.push_back(2'b00); exp_a_q.push_back(2'b10);
    expect_ta(32'hABCD_EF01, 1'b0, 1'b1);
    do_xfer("line_tbi", 2'b00, 2'b11, 1'b1, 32'd0, 2, 1, 0, 0, 1'b0);

    // Long write through a 16-bit port: steering per sub-cycle
    add_resp(2'b01, 32'd0, 0, 1, 1, 1);
    add_resp(2'b01, 32'd0, 0, 1, 1, 1);
    exp_a_q.push_back(2'b00); exp_a_q.push_back(2'b10);
    exp_wd_q.push_back(8'hCA); exp_wd_q.push_back(8'hBA);
    expect_ta(32'd0, 1'b1, 1'b1);
    do_xfer("long_wr16", 2'b00, 2'b00, 1'b0, 32'hCAFE_BABE, 2, 1, 0, 0, 1'b0);

    // Bus error together with DSACK: error wins, no data committed
    add_resp(2'b00, 32'h9999_9999, 1, 0, 1, 1);
    exp_a_q.push_back(2'b00);
    do_xfer("tea_vs_dsack", 2'b00, 2'b00, 1'b1, 32'd0, 1, 0, 1, 0, 1'b0);
    check("tea_no_commit", bif.CPU_RD, 32'hABCD_EF01);

    // Timeout: DSACK never arrives
    add_resp(2'b00, 32'd0, 255, 1, 1, 1);
    exp_a_q.push_back(2'b00);
    do_xfer("timeout", 2'b00, 2'b10, 1'b1, 32'd0, 1, 0, 1, 0, 1'b0);
    check("timeout_latency", 32'(ntea_cyc - last_nts_cyc), 32'd64);

    // Reset during the second sub-cycle of a long read
    add_resp(2'b01, 32'h1234_0000, 0, 1, 1, 1);
    add_resp(2'b01, 32'h5678_0000, 0, 1, 1, 1);
    exp_a_q.push_back(2'b00); exp_a_q.push_back(2'b10);
    do_xfer("mid_reset", 2'b00, 2'b00, 1'b1, 32'd0, 2, 1, 0, 2, 1'b0);
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;
    resp_q.delete(); exp_a_q.delete(); exp_wd_q.delete();
    exp_rd_q.delete(); exp_tbi_q.delete(); exp_tci_q.delete();

    // Normal service after reset
    add_resp(2'b01, 32'h9ABC_0000, 0, 1, 1, 1);
    add_resp(2'b01, 32'hDEF0_0000, 0, 1, 1, 1);
    exp_a_q.push_back(2'b00); exp_a_q.push_back(2'b10);
    expect_ta(32'h9ABC_DEF0, 1'b1, 1'b1);
    do_xfer("after_reset", 2'b00, 2'b00, 1'b1, 32'd0, 2, 1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
